// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp, msip, machine timer/software IRQ sources.
// Latency: bus response one cycle after the request; timer_irq_o one cycle after mtime/mtimecmp change.
// Backpressure: none; every cycle with req_i=1 is accepted and acked exactly once.
module clint_timer #(
  parameter int unsigned PRESCALE = 1,
  parameter logic [31:0] HART_ID  = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] timer_val_low_o,
  output logic [31:0] timer_val_high_o,
  output logic        timer_irq_o,
  output logic        soft_irq_o,
  output logic [31:0] mhartid_o,
  input  logic        time_en_i
);

  localparam logic [15:0] ADDR_MSIP     = 16'h0000;
  localparam logic [15:0] ADDR_MTCMP_LO = 16'h4000;
  localparam logic [15:0] ADDR_MTCMP_HI = 16'h4004;
  localparam logic [15:0] ADDR_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] ADDR_MTIME_HI = 16'hBFFC;

  // Terminal count of the prescaler; PRESCALE is limited to 1..65535.
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [63:0] mtime;
  logic [63:0] mtime_nxt;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [15:0] pre_cnt;
  logic        tick;

  logic        sel_msip;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        sel_mt_lo;
  logic        sel_mt_hi;
  logic        hit;
  logic        wr;
  logic [31:0] rd_word;

  // Byte-lane merge of write data into an existing word.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] data,
                                        input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  // Full 16-bit compare also rejects misaligned offsets, since every mapped
  // address has addr[1:0] == 0.
  assign sel_msip   = req_i && (addr_i == ADDR_MSIP);
  assign sel_cmp_lo = req_i && (addr_i == ADDR_MTCMP_LO);
  assign sel_cmp_hi = req_i && (addr_i == ADDR_MTCMP_HI);
  assign sel_mt_lo  = req_i && (addr_i == ADDR_MTIME_LO);
  assign sel_mt_hi  = req_i && (addr_i == ADDR_MTIME_HI);
  assign hit        = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi;
  assign wr         = req_i && we_i;

  assign tick = time_en_i && (pre_cnt == PRE_LAST);

  // Read mux over current register values (pre-tick snapshot).
  always_comb begin
    rd_word = 32'd0;
    if (sel_msip)   rd_word = {31'd0, msip};
    if (sel_cmp_lo) rd_word = mtimecmp[31:0];
    if (sel_cmp_hi) rd_word = mtimecmp[63:32];
    if (sel_mt_lo)  rd_word = mtime[31:0];
    if (sel_mt_hi)  rd_word = mtime[63:32];
  end

  // Prescaler: counts enabled cycles and wraps at PRESCALE-1; bus writes never disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= 16'd0;
    end else if (time_en_i) begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
    end
  end

  // Next mtime: a bus write to either half wins over the tick increment.
  always_comb begin
    mtime_nxt = mtime;
    if (wr && sel_mt_lo) begin
      mtime_nxt[31:0] = merge(mtime[31:0], wdata_i, be_i);
    end else if (wr && sel_mt_hi) begin
      mtime_nxt[63:32] = merge(mtime[63:32], wdata_i, be_i);
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
  end

  // mtime register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mtime <= 64'd0;
    else     mtime <= mtime_nxt;
  end

  // mtimecmp and msip registers, written with byte-lane merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip     <= 1'b0;
    end else if (wr) begin
      if (sel_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0], wdata_i, be_i);
      if (sel_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], wdata_i, be_i);
      if (sel_msip && be_i[0]) msip <= wdata_i[0];
    end
  end

  // Bus response: one-cycle ack, error on unmapped/misaligned, data only on good reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end else begin
      ack_o   <= req_i;
      err_o   <= req_i && !hit;
      rdata_o <= (req_i && !we_i && hit) ? rd_word : 32'd0;
    end
  end

  // Timer interrupt level, compared on the committed register values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_irq_o <= 1'b0;
    else     timer_irq_o <= (mtime >= mtimecmp);
  end

  assign soft_irq_o       = msip;
  assign timer_val_low_o  = mtime[31:0];
  assign timer_val_high_o = mtime[63:32];
  assign mhartid_o        = HART_ID;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one PRESCALE=1 instance on the bus, one PRESCALE=4 instance for prescaler timing.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Every bound on a DUT event is a fixed cycle count.
module tb_clint_timer;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] tlo;
  logic [31:0] thi;
  logic        tirq;
  logic        sirq;
  logic [31:0] hart;
  logic        ten;

  logic        req4;
  logic        we4;
  logic [15:0] addr4;
  logic [31:0] wdata4;
  logic [3:0]  be4;
  logic        ack4;
  logic        err4;
  logic [31:0] rdata4;
  logic [31:0] tlo4;
  logic [31:0] thi4;
  logic        tirq4;
  logic        sirq4;
  logic [31:0] hart4;
  logic        ten4;

  int          tests;
  int          fails;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] v0;
  logic [31:0] prev;
  logic        found;

  clint_timer #(.PRESCALE(1), .HART_ID(32'h0000_0003)) u_dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .be_i(be), .ack_o(ack), .err_o(err), .rdata_o(rdata), .timer_val_low_o(tlo),
    .timer_val_high_o(thi), .timer_irq_o(tirq), .soft_irq_o(sirq), .mhartid_o(hart),
    .time_en_i(ten)
  );

  clint_timer #(.PRESCALE(4), .HART_ID(32'h0000_0000)) u_dut4 (
    .clk(clk), .rst(rst), .req_i(req4), .we_i(we4), .addr_i(addr4), .wdata_i(wdata4),
    .be_i(be4), .ack_o(ack4), .err_o(err4), .rdata_o(rdata4), .timer_val_low_o(tlo4),
    .timer_val_high_o(thi4), .timer_irq_o(tirq4), .soft_irq_o(sirq4), .mhartid_o(hart4),
    .time_en_i(ten4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one request for one cycle and
  // captures the response at the next falling edge.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    @(negedge clk);
    r_ack   = ack;
    r_err   = err;
    r_rdata = rdata;
    req   = 1'b0;
    we    = 1'b0;
    be    = 4'd0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; ten = 1'b1; ten4 = 1'b1;
    req = 1'b0; we = 1'b0; addr = 16'd0; wdata = 32'd0; be = 4'd0;
    req4 = 1'b0; we4 = 1'b0; addr4 = 16'd0; wdata4 = 32'd0; be4 = 4'd0;
    r_ack = 1'b0; r_err = 1'b0; r_rdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_tlo", tlo, 0);
    check("rst_thi", thi, 0);
    check("rst_tirq", tirq, 0);
    check("rst_sirq", sirq, 0);
    check("rst_tlo4", tlo4, 0);
    rst = 1'b0;

    // Free-running count, 10 idle cycles
    repeat (10) @(negedge clk);
    check("count10", (tlo >= 32'd9 && tlo <= 32'd11), 1);
    check("irq_idle", tirq, 0);
    check("sirq_idle", sirq, 0);
    check("hartid", hart, 32'h3);
    check("rdata_noack", rdata, 0);

    // msip write/read/clear
    do_req(1'b1, 16'h0000, 32'h1, 4'hF);
    check("msip_w_ack", r_ack, 1);
    check("msip_w_err", r_err, 0);
    check("msip_set", sirq, 1);
    do_req(1'b0, 16'h0000, 32'h0, 4'h0);
    check("msip_r_ack", r_ack, 1);
    check("msip_rdata", r_rdata, 32'h1);
    do_req(1'b1, 16'h0000, 32'h0, 4'hF);
    check("msip_clr", sirq, 0);

    // Read of mtime_lo returns the pre-tick value
    v0 = tlo;
    do_req(1'b0, 16'hBFF8, 32'h0, 4'h0);
    check("mtlo_rd", r_rdata, v0);
    check("mtlo_adv", tlo, v0 + 32'd1);

    // Carry and compare
    do_req(1'b1, 16'h4004, 32'h1, 4'hF);
    do_req(1'b1, 16'h4000, 32'h0, 4'hF);
    do_req(1'b1, 16'hBFFC, 32'h0, 4'hF);
    do_req(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    check("pre_lo", tlo, 32'hFFFF_FFFE);
    check("pre_hi", thi, 0);
    check("pre_irq", tirq, 0);
    @(negedge clk);
    check("ff_lo", tlo, 32'hFFFF_FFFF);
    check("ff_hi", thi, 0);
    @(negedge clk);
    check("carry_hi", thi, 1);
    check("carry_lo", tlo, 0);
    check("irq_lat", tirq, 0);
    @(negedge clk);
    check("irq_rise", tirq, 1);
    do_req(1'b1, 16'h4004, 32'h2, 4'hF);
    check("irq_hold", tirq, 1);
    @(negedge clk);
    check("irq_fall", tirq, 0);
    do_req(1'b0, 16'h4004, 32'h0, 4'h0);
    check("cmphi_rd", r_rdata, 32'h2);

    // Partial mtime_lo write in a tick cycle
    v0 = tlo;
    do_req(1'b1, 16'hBFF8, 32'h1234_5678, 4'b0011);
    check("be_ack", r_ack, 1);
    check("be_lo", tlo, {v0[31:16], 16'h5678});
    check("be_hi", thi, 1);
    @(negedge clk);
    check("be_next", tlo, {v0[31:16], 16'h5679});

    // Error responses leave state untouched
    do_req(1'b0, 16'h4002, 32'h0, 4'h0);
    check("err1_ack", r_ack, 1);
    check("err1_err", r_err, 1);
    check("err1_rdata", r_rdata, 0);
    do_req(1'b0, 16'h1000, 32'h0, 4'h0);
    check("err2_err", r_err, 1);
    check("err2_rdata", r_rdata, 0);
    do_req(1'b1, 16'h0002, 32'h1, 4'hF);
    check("err3_err", r_err, 1);
    check("err3_msip", sirq, 0);
    v0 = tlo;
    do_req(1'b1, 16'hBFF9, 32'h0, 4'hF);
    check("err4_err", r_err, 1);
    check("err4_mtime", tlo, v0 + 32'd1);
    do_req(1'b0, 16'h0000, 32'h0, 4'h0);
    check("ok_after_err", r_err, 0);

    // Prescaler: align to a tick edge on the PRESCALE=4 instance
    prev  = tlo4;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (tlo4 != prev) found = 1'b1;
      prev = tlo4;
    end
    check("pre4_tick_seen", found, 1);
    v0 = tlo4;
    repeat (3) @(negedge clk);
    check("pre4_hold3", tlo4, v0);
    @(negedge clk);
    check("pre4_tick", tlo4, v0 + 32'd1);
    ten4 = 1'b0;
    repeat (8) @(negedge clk);
    check("pre4_frozen", tlo4, v0 + 32'd1);
    ten4 = 1'b1;
    repeat (3) @(negedge clk);
    check("pre4_resume3", tlo4, v0 + 32'd1);
    @(negedge clk);
    check("pre4_resume4", tlo4, v0 + 32'd2);

    // Reset between request and ack
    do_req(1'b1, 16'h0000, 32'h1, 4'hF);
    check("msip_reset_pre", sirq, 1);
    req = 1'b1; we = 1'b0; addr = 16'h0000;
    @(posedge clk);
    #2;
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    check("arst_ack", ack, 0);
    check("arst_err", err, 0);
    check("arst_rdata", rdata, 0);
    check("arst_sirq", sirq, 0);
    check("arst_tirq", tirq, 0);
    check("arst_tlo", tlo, 0);
    check("arst_thi", thi, 0);
    rst = 1'b0;
    do_req(1'b0, 16'h4000, 32'h0, 4'h0);
    check("post_rst_ack", r_ack, 1);
    check("post_rst_err", r_err, 0);
    check("post_rst_cmp", r_rdata, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
